reg_alu_sequencer: RTL
======================

Name: reg_alu_sequencer

Overview:
- Execution sequencer directly upstream of the 256 x 8-bit register unit; drives its single read port and its write port.
- Accepts one register-to-register instruction (op, rs1, rs2, rd) per valid/ready handshake.
- Fetches both operands sequentially through the one read port, computes an 8-bit ALU result, writes it back to rd and updates zero/carry flags.

Parameters:
- DATA_W, 8, register data width; must match the register unit.
- ADDR_W, 8, register address width; must match the register unit.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- instr_valid  input  1  instruction fields valid.
- instr_ready  output  1  sequencer can accept an instruction.
- instr_op  input  3  operation code.
- instr_rs1  input  ADDR_W  source A register address.
- instr_rs2  input  ADDR_W  source B register address.
- instr_rd  input  ADDR_W  destination register address.
- rf_read_address  output  ADDR_W  to register unit read_address.
- rf_read_data  input  DATA_W  from register unit read_data; combinational, same cycle as address.
- rf_write_address  output  ADDR_W  to register unit write_address.
- rf_write_data  output  DATA_W  to register unit write_data.
- rf_write_enable  output  1  to register unit write_enable.
- done  output  1  one-cycle pulse when an instruction retires.
- flag_zero  output  1  registered zero flag.
- flag_carry  output  1  registered carry/borrow flag.

Behaviour:
- Clock, reset and polarity are fixed: one clock `clk`; `rst` is synchronous and active-high.
- Reset: clears every register, which fixes the value of every output.
  - State goes to IDLE.
  - instr_ready = 0 in any cycle with rst high.
  - rf_read_address, rf_write_address and rf_write_data = 0.
  - rf_write_enable, done, flag_zero and flag_carry = 0.
- Reset mid-instruction: discards the instruction, performs no write, returns to IDLE with flags cleared.
- FSM states: IDLE, READ_A, READ_B, WRITE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid and instr_ready: latch op, rs1, rs2 and rd, then go to READ_A.
  - Otherwise stay in IDLE.
- READ_A:
  - rf_read_address = latched rs1.
  - Capture rf_read_data into opA at the clock edge, then go to READ_B.
- READ_B:
  - rf_read_address = latched rs2.
  - Capture into opB, then go to WRITE.
- WRITE:
  - rf_write_address = rd and rf_write_data = result.
  - rf_write_enable = 1, except for op CMP.
  - done = 1 for this cycle only.
  - Flags update at the end of this cycle; go to IDLE.
- Read address in other states: rf_read_address = 0 in IDLE and WRITE.
- Output timing: every output is derived only from the state register and latched fields. There is no combinational path from instr_* inputs to any output.
- Latency and throughput:
  - Accept edge to write edge is 3 cycles.
  - Back-to-back accepts are 4 cycles apart.
  - instr_ready is low in READ_A, READ_B and WRITE.
- Operation codes (result is 8 bits):
  - 000 ADD: A+B; carry = bit 8 of the 9-bit sum.
  - 001 SUB: A-B mod 256; carry = borrow (1 when A<B unsigned).
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 MOV: result = A; carry = 0.
  - 110 SHL: result = A<<1; carry = A[7].
  - 111 CMP: flags as SUB; no write (rf_write_enable stays 0); done still pulses.
- flag_zero = (result == 0), for every op including CMP.
- Hazards: none. A write lands at the edge ending WRITE, before any later READ_A, so RAW through the register unit is always correct.
- rd equal to rs1 or rs2: legal; operands are already captured before the write.

Optional Feature:
- Macro: REG_SEQ_OPERAND_SKIP_EN.
- Defined: when latched rs1 == rs2, READ_A goes directly to WRITE with opB = opA.
  - Such instructions take 3 cycles accept-to-accept; write at the 2nd edge after accept.
  - All other behaviour is unchanged.
- Undefined: READ_B is always visited; timing is fixed at 4 cycles.

Test Plan:
- Reset, then preload r1=0x0F and r2=0xF1, then ADD rd=3 -> r3=0x00, flag_zero=1, flag_carry=1, done 3 cycles after accept.
- SUB r1=0x05, r2=0x07, rd=4 -> r4=0xFE, carry=1, zero=0. CMP of the same registers -> no write (r4 unchanged), same flags.
- Hold instr_valid high with three back-to-back ADDs -> accepts exactly 4 cycles apart. instr_ready is low in the 3 intermediate cycles, and rf_read_address shows rs1 then rs2.
- SHL r5=0x81, rd=5 -> r5=0x02, carry=1. An immediately following MOV rs1=5, rd=6 -> r6=0x02, proving no RAW hazard.
- Assert rst during READ_B of an XOR -> no rf_write_enable pulse, no done, flags 0; the next instruction executes normally.
- With REG_SEQ_OPERAND_SKIP_EN, AND rs1=rs2=7 (r7=0x3C), rd=8 -> r8=0x3C, done 2 cycles after accept, READ_B never entered. Without the macro, done comes 3 cycles after accept.

Source files
------------

// File: rtl/reg_alu_sequencer_if.sv
// reg_alu_sequencer_if: instruction handshake plus register-unit read/write bus for the sequencer
interface reg_alu_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] rf_read_address;
  logic [DATA_W-1:0] rf_read_data;
  logic [ADDR_W-1:0] rf_write_address;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_write_enable;
  modport master (
    output instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd, rf_read_data,
    input  instr_ready, rf_read_address, rf_write_address, rf_write_data, rf_write_enable
  );
  modport slave (
    input  instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd, rf_read_data,
    output instr_ready, rf_read_address, rf_write_address, rf_write_data, rf_write_enable
  );
endinterface

// File: rtl/reg_alu_sequencer.sv
// reg_alu_sequencer: fetch rs1/rs2 over one read port, ALU, write rd; REG_SEQ_OPERAND_SKIP_EN skips READ_B when rs1 == rs2
module reg_alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_alu_sequencer_if.slave   bus,
  output logic                 done,
  output logic                 flag_zero,
  output logic                 flag_carry
);
  localparam logic [1:0] IDLE = 2'd0, READ_A = 2'd1, READ_B = 2'd2, WRITE = 2'd3;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3, XOR = 3'd4, MOV = 3'd5, CMP = 3'd7;
  logic [1:0]        state;
  logic [2:0]        op;
  logic [ADDR_W-1:0] rs1, rs2, rd;
  logic [DATA_W-1:0] op_a, op_b, result;
  logic [DATA_W:0]   sum, diff;
  logic              carry, wr;
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};
  always_comb begin
    result = op == ADD ? sum[DATA_W-1:0] :
             (op == SUB || op == CMP) ? diff[DATA_W-1:0] :
             op == AND ? op_a & op_b :
             op == OR  ? op_a | op_b :
             op == XOR ? op_a ^ op_b :
             op == MOV ? op_a : {op_a[DATA_W-2:0], 1'b0};
    carry  = op == ADD ? sum[DATA_W] :
             (op == SUB || op == CMP) ? diff[DATA_W] :
             (op == AND || op == OR || op == XOR || op == MOV) ? 1'b0 : op_a[DATA_W-1];
  end
  assign wr                   = state == WRITE;
  assign bus.instr_ready      = state == IDLE && !rst;
  assign bus.rf_read_address  = state == READ_A ? rs1 : state == READ_B ? rs2 : '0;
  assign bus.rf_write_address = wr ? rd : '0;
  assign bus.rf_write_data    = wr ? result : '0;
  assign bus.rf_write_enable  = wr && op != CMP;
  assign done                 = wr;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op         <= '0;
      rs1        <= '0;
      rs2        <= '0;
      rd         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.instr_valid) begin
          op    <= bus.instr_op;
          rs1   <= bus.instr_rs1;
          rs2   <= bus.instr_rs2;
          rd    <= bus.instr_rd;
          state <= READ_A;
        end
        READ_A: begin
          op_a <= bus.rf_read_data;
`ifdef REG_SEQ_OPERAND_SKIP_EN
          if (rs1 == rs2) begin
            op_b  <= bus.rf_read_data;
            state <= WRITE;
          end else begin
            state <= READ_B;
          end
`else
          state <= READ_B;
`endif
        end
        READ_B: begin
          op_b  <= bus.rf_read_data;
          state <= WRITE;
        end
        default: begin
          flag_zero  <= result == '0;
          flag_carry <= carry;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule
